// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
//   CPU-side initiator for the 32-bit single-port data RAM. Accepts byte-
//   addressed RV32 load/store requests and turns them into word accesses:
//   lane selection, sign/zero extension, alignment/range checking and the
//   one-cycle RAM read latency. The RAM byteMask only encodes access size
//   anchored at lane 0, so sub-word stores at a nonzero offset are done as a
//   read-modify-write of the whole word.
//
// Ports
//   clk, reset        clock; synchronous active-low reset
//   req_valid/ready   request handshake (ready only while idle)
//   req_write         1 = store, 0 = load
//   req_funct3        RV32 size/sign code (LB/LH/LW/LBU/LHU, SB/SH/SW)
//   req_addr          byte address
//   req_wdata         store data, right-justified
//   resp_valid        one-cycle completion pulse
//   resp_err          misaligned / illegal funct3 / out of range
//   resp_rdata        extended load data (0 for stores and errors)
//   memAddress        word index into the RAM
//   memWriteData      RAM write data
//   memWrite          RAM write strobe
//   byteMask          RAM size code: 0001 byte, 0011 half, 1111 word
//   memReadData       RAM read data, valid the cycle after memAddress
// ---------------------------------------------------------------------------
module mem_access_unit #(
  parameter int unsigned MEM_WORDS = 32768
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic [31:0] memAddress,
  output logic [31:0] memWriteData,
  output logic        memWrite,
  output logic [3:0]  byteMask,
  input  logic [31:0] memReadData
);

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WRITE,
    RESP
  } state_t;

  state_t      state_q, state_d;
  logic        write_q, write_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d;
  logic        err_q, err_d;
  logic [31:0] wdata_q, wdata_d;   // store data, later replaced by the merged RMW word
  logic [3:0]  mask_q, mask_d;
  logic [31:0] rdata_q, rdata_d;

  // Request decode (only used to compute what gets latched on accept)
  logic        f3_ok;
  logic        misaligned;
  logic        out_of_range;
  logic        req_err;
  logic        req_rmw;
  logic [3:0]  req_size_mask;

  always_comb begin
    if (req_write) begin
      f3_ok = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010);
    end else begin
      f3_ok = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010) ||
              (req_funct3 == 3'b100) || (req_funct3 == 3'b101);
    end
    misaligned   = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    out_of_range = {2'b00, req_addr[31:2]} >= MEM_WORDS;
    req_err      = !f3_ok || misaligned || out_of_range;
    // For a legal store a nonzero offset can only be SB@1/2/3 or SH@2.
    req_rmw      = req_write && (req_addr[1:0] != 2'b00);
    case (req_funct3[1:0])
      2'b00:   req_size_mask = 4'b0001;
      2'b01:   req_size_mask = 4'b0011;
      default: req_size_mask = 4'b1111;
    endcase
  end

  // Read-data lane handling
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_ext;
  logic [31:0] merged;

  always_comb begin
    rd_byte = memReadData[{addr_q[1:0], 3'b000} +: 8];
    rd_half = addr_q[1] ? memReadData[31:16] : memReadData[15:0];
    case (funct3_q)
      3'b000:  load_ext = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  load_ext = {{16{rd_half[15]}}, rd_half};
      3'b100:  load_ext = {24'h000000, rd_byte};
      3'b101:  load_ext = {16'h0000, rd_half};
      default: load_ext = memReadData;
    endcase
    merged = memReadData;
    if (funct3_q[1:0] == 2'b00) begin
      merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    end else begin
      merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end
  end

  always_comb begin
    state_d  = state_q;
    write_d  = write_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    err_d    = err_q;
    wdata_d  = wdata_q;
    mask_d   = mask_q;
    rdata_d  = rdata_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d  = req_write;
          funct3_d = req_funct3;
          addr_d   = req_addr;
          err_d    = req_err;
          wdata_d  = req_wdata;
          rdata_d  = '0;
          mask_d   = (req_write && !req_rmw && !req_err) ? req_size_mask : 4'b1111;
          if (req_err) begin
            state_d = RESP;
          end else if (!req_write || req_rmw) begin
            state_d = RD_ADDR;
          end else begin
            state_d = WRITE;
          end
        end
      end
      RD_ADDR: state_d = RD_DATA;
      RD_DATA: begin
        if (write_q) begin
          wdata_d = merged;
          mask_d  = 4'b1111;
          state_d = WRITE;
        end else begin
          rdata_d = load_ext;
          state_d = RESP;
        end
      end
      WRITE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      write_q  <= 1'b0;
      funct3_q <= '0;
      addr_q   <= '0;
      err_q    <= 1'b0;
      wdata_q  <= '0;
      mask_q   <= '1;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      write_q  <= write_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      err_q    <= err_d;
      wdata_q  <= wdata_d;
      mask_q   <= mask_d;
      rdata_q  <= rdata_d;
    end
  end

  assign req_ready    = (state_q == IDLE);
  assign resp_valid   = (state_q == RESP);
  assign resp_err     = (state_q == RESP) && err_q;
  assign resp_rdata   = rdata_q;
  assign memAddress   = {2'b00, addr_q[31:2]};
  assign memWriteData = wdata_q;
  assign memWrite     = (state_q == WRITE);
  assign byteMask     = mask_q;

endmodule
